// File: rtl/elevator_call_panel.sv
// elevator_call_panel: latches five floor calls and sequences serve/door-open stops
module elevator_call_panel #(
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  input  logic [2:0] floor,
  output logic       rgnd,
  output logic       r1st,
  output logic       r2nd,
  output logic       r3rd,
  output logic       r4th,
  output logic [4:0] pending,
  output logic       door_open,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SERVE, DOOR} state_t;
  localparam logic [3:0] RELOAD = 4'(DOOR_CYCLES - 1);
  state_t     state_q, state_d;
  logic [4:0] pending_q, pending_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] cap_q, cap_d;
  logic [4:0] latched, cur_oh, cap_oh, r;
  logic       hit, moved, hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
    end
  end
  always_comb begin
    latched   = pending_q | btn;
    cur_oh    = 5'(8'b1 << floor);
    cap_oh    = 5'(8'b1 << cap_q);
    hit       = |(cur_oh & pending_q);
    moved     = floor != cap_q;
    hold      = |(cap_oh & btn);
    state_d   = state_q;
    pending_d = latched;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    case (state_q)
      IDLE:  state_d = |latched ? SERVE : IDLE;
      SERVE: if (hit) begin
        state_d = DOOR;
        cnt_d   = RELOAD;
        cap_d   = floor;
      end
      DOOR:
        if (moved) state_d = SERVE;
        else if (hold) cnt_d = RELOAD;
        else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          pending_d = latched & ~cap_oh;
          state_d   = |pending_d ? SERVE : IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    r = state_q == DOOR ? cap_oh : state_q == SERVE ? pending_q : 5'b0;
  end
  assign {r4th, r3rd, r2nd, r1st, rgnd} = r;
  assign pending   = pending_q;
  assign door_open = state_q == DOOR;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_elevator_call_panel.sv
// tb_elevator_call_panel: directed stimulus with a queued scoreboard for elevator_call_panel
module tb_elevator_call_panel;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic [2:0] floor;
  logic       rgnd, r1st, r2nd, r3rd, r4th, door_open, busy;
  logic [4:0] pending;
  typedef struct {
    int          cyc;
    logic [11:0] exp;
    string       name;
  } item_t;
  item_t sb[$];
  item_t it;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  elevator_call_panel #(.DOOR_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn(btn), .floor(floor),
    .rgnd(rgnd), .r1st(r1st), .r2nd(r2nd), .r3rd(r3rd), .r4th(r4th),
    .pending(pending), .door_open(door_open), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      checks++;
      if (it.cyc != cyc || {busy, door_open, r4th, r3rd, r2nd, r1st, rgnd, pending} !== it.exp) begin
        errors++;
        $display("FAIL %s cyc %0d: got busy/door/r/pending=%b_%b_%b_%b want %b_%b_%b_%b",
                 it.name, cyc, busy, door_open, {r4th, r3rd, r2nd, r1st, rgnd}, pending,
                 it.exp[11], it.exp[10], it.exp[9:5], it.exp[4:0]);
      end
    end
  end
  task automatic step(input string n, input bit r_in, input logic [4:0] b, input logic [2:0] f,
                      input logic [4:0] p, input logic [4:0] rq, input bit d, input bit bz);
    rst   = r_in;
    btn   = b;
    floor = f;
    sb.push_back('{cyc + 1, {bz, d, rq, p}, n});
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step("reset", 1, 5'b00000, 3'd0, 5'b00000, 5'b00000, 0, 0);
    step("single_latch", 0, 5'b00100, 3'd0, 5'b00100, 5'b00100, 0, 1);
    step("single_wait1", 0, 5'b00000, 3'd0, 5'b00100, 5'b00100, 0, 1);
    step("single_wait2", 0, 5'b00000, 3'd0, 5'b00100, 5'b00100, 0, 1);
    for (int i = 0; i < 4; i++)
      step("single_door", 0, 5'b00000, 3'd2, 5'b00100, 5'b00100, 1, 1);
    step("single_done", 0, 5'b00000, 3'd2, 5'b00000, 5'b00000, 0, 0);
    step("here_latch", 0, 5'b01000, 3'd3, 5'b01000, 5'b01000, 0, 1);
    for (int i = 0; i < 4; i++)
      step("here_door", 0, 5'b00000, 3'd3, 5'b01000, 5'b01000, 1, 1);
    step("here_done", 0, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, 0);
    step("hold_latch", 0, 5'b00010, 3'd1, 5'b00010, 5'b00010, 0, 1);
    for (int i = 0; i < 4; i++)
      step("hold_door", 0, 5'b00000, 3'd1, 5'b00010, 5'b00010, 1, 1);
    step("hold_reload", 0, 5'b00010, 3'd1, 5'b00010, 5'b00010, 1, 1);
    for (int i = 0; i < 3; i++)
      step("hold_after", 0, 5'b00000, 3'd1, 5'b00010, 5'b00010, 1, 1);
    step("hold_done", 0, 5'b00000, 3'd1, 5'b00000, 5'b00000, 0, 0);
    step("multi_latch", 0, 5'b10001, 3'd0, 5'b10001, 5'b10001, 0, 1);
    step("multi_door0", 0, 5'b00000, 3'd0, 5'b10001, 5'b00001, 1, 1);
    step("multi_other", 0, 5'b00100, 3'd0, 5'b10101, 5'b00001, 1, 1);
    step("multi_door0", 0, 5'b00000, 3'd0, 5'b10101, 5'b00001, 1, 1);
    step("multi_door0", 0, 5'b00000, 3'd0, 5'b10101, 5'b00001, 1, 1);
    step("multi_exit0", 0, 5'b00000, 3'd0, 5'b10100, 5'b10100, 0, 1);
    for (int i = 0; i < 4; i++)
      step("multi_door4", 0, 5'b00000, 3'd4, 5'b10100, 5'b10000, 1, 1);
    step("multi_exit4", 0, 5'b00000, 3'd4, 5'b00100, 5'b00100, 0, 1);
    step("abort_door2", 0, 5'b00000, 3'd2, 5'b00100, 5'b00100, 1, 1);
    step("abort_move", 0, 5'b00000, 3'd1, 5'b00100, 5'b00100, 0, 1);
    step("abort_serve", 0, 5'b00000, 3'd1, 5'b00100, 5'b00100, 0, 1);
    step("inval_latch", 0, 5'b11111, 3'd6, 5'b11111, 5'b11111, 0, 1);
    step("inval_nodoor", 0, 5'b00000, 3'd6, 5'b11111, 5'b11111, 0, 1);
    step("inval_nodoor", 0, 5'b00000, 3'd7, 5'b11111, 5'b11111, 0, 1);
    step("reset2", 1, 5'b00000, 3'd0, 5'b00000, 5'b00000, 0, 0);
    step("rd_latch", 0, 5'b00100, 3'd2, 5'b00100, 5'b00100, 0, 1);
    step("rd_door", 0, 5'b00000, 3'd2, 5'b00100, 5'b00100, 1, 1);
    step("rd_door", 0, 5'b00000, 3'd2, 5'b00100, 5'b00100, 1, 1);
    step("rd_reset", 1, 5'b11111, 3'd2, 5'b00000, 5'b00000, 0, 0);
    step("rd_idle", 0, 5'b00000, 3'd2, 5'b00000, 5'b00000, 0, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_call_panel.md
ELEVATOR_CALL_PANEL -- requirements
Module: elevator_call_panel

Interface
REQ-001 Parameter: DOOR_CYCLES, default 4, number of clock cycles door_open stays high per stop (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn  input  5  call buttons, level; bit0 = ground, bit1 = first, bit2 = second, bit3 = third, bit4 = fourth floor.
REQ-005 floor  input  3  current car floor from the elevator controller, 0..4; values 5..7 are invalid.
REQ-006 rgnd, r1st, r2nd, r3rd, r4th  output  1 each  floor requests to the elevator controller.
REQ-007 pending  output  5  latched call register, same bit mapping as btn.
REQ-008 door_open  output  1  door-open indication.
REQ-009 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-010 FSM states SHALL be IDLE, SERVE and DOOR, plus a 4-bit door counter cnt.
REQ-011 Latching: pending_next[i] = pending[i] | btn[i], minus any clear per REQ-017.
- A press is latched on the first posedge where btn[i] is sampled high.
- A press is visible on pending and on the r* outputs in the cycle following that edge.
REQ-012 IDLE -> SERVE on the edge where pending_next != 0; otherwise remain in IDLE.
REQ-013 SERVE -> DOOR on the edge where floor <= 4 and pending[floor] = 1.
- On that edge cnt SHALL load DOOR_CYCLES-1.
REQ-014 SERVE SHALL remain in SERVE while there is no match at the current floor.
- Invalid floor (5..7) never matches.
REQ-015 DOOR: door_open = 1; cnt decrements each cycle while cnt != 0.
REQ-016 DOOR with btn[floor] = 1 on any cycle SHALL reload cnt to DOOR_CYCLES-1 (door hold); pending[floor] is not cleared on that edge.
REQ-017 DOOR with cnt = 0 and btn[floor] = 0 SHALL, on that edge:
- clear pending[floor];
- go to SERVE if any other pending bit (including calls newly latched on the same edge) is set, else to IDLE.
REQ-018 DOOR with floor changed from the value captured on DOOR entry SHALL go to SERVE on that edge.
- No pending bit is cleared.
- door_open drops.
REQ-019 Request outputs are combinational from registered state:
- IDLE: all r* = 0.
- SERVE: r* = pending.
- DOOR: only the r* bit of the captured floor = 1, holding the car at that floor.
REQ-020 door_open SHALL be 1 only in DOOR; busy = (state != IDLE).
REQ-021 Total door-open time without holds SHALL be exactly DOOR_CYCLES cycles.
REQ-022 Simultaneous presses on multiple floors SHALL all latch in the same edge.
REQ-023 Presses of other floors during DOOR SHALL latch without affecting cnt.
REQ-024 Pressing btn[i] while pending[i] = 1 SHALL have no effect outside REQ-016.

Reset
REQ-025 rst = 1 sampled at posedge SHALL force, on that edge:
- state = IDLE, pending = 0, cnt = 0, captured floor = 0;
- door_open = 0, busy = 0, all r* = 0.
REQ-026 rst SHALL take priority over btn and all FSM transitions, including reset asserted mid-DOOR.
REQ-027 Presses sampled in the same cycle as rst SHALL be discarded.

Verification (DOOR_CYCLES = 4)
REQ-028 Single call: floor = 0, btn = 00100 for 1 cycle, then floor steps to 2 after 3 cycles -> expected response:
- pending = 00100, r2nd = 1, busy = 1 from the next cycle;
- DOOR entered the edge after floor = 2;
- door_open high exactly 4 cycles;
- then pending = 0, busy = 0, r2nd = 0.
REQ-029 Call at current floor: floor = 3, IDLE, btn = 01000 one cycle -> expected response:
- SERVE one cycle, then door_open = 1 for 4 cycles with only r3rd = 1;
- then IDLE.
REQ-030 Door hold: in DOOR at floor 1, btn = 00010 at cnt = 0 -> expected response:
- cnt reloads to 3, door_open stays 1 for 4 further cycles;
- pending[1] cleared only afterwards.
REQ-031 Multiple calls: btn = 10001 at floor 0 -> expected response:
- DOOR at 0 with only rgnd = 1;
- exit to SERVE with pending = 10000, r4th = 1;
- floor = 4 gives a second 4-cycle door.
REQ-032 Abort and invalid floor -> expected response:
- floor changes 2 -> 1 during DOOR: SERVE next cycle, pending[2] retained;
- floor = 6 with pending = 11111: no DOOR entry.
REQ-033 Reset mid-DOOR: rst for 1 cycle at cnt = 2 -> expected response:
- next cycle all outputs 0, state IDLE;
- btn held high during rst not latched.
